gate_test_sequencer: RTL
========================

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: clocks waited after applying a vector before sampling (legal range 0..15).
REQ-002 The block SHALL have parameter TRUTH_TABLE, default 4'b1000: expected gate output, where bit i is the expected output for vector i = {in1,in2} (default is 2-input AND).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port clk: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port start: input, 1 bit, request to run one full test sweep.
REQ-007 Port dut_out: input, 1 bit, output of the gate under test.
REQ-008 Port dut_in1: output, 1 bit, first gate input.
REQ-009 Port dut_in2: output, 1 bit, second gate input.
REQ-010 Port busy: output, 1 bit, high while a sweep is in progress.
REQ-011 Port done: output, 1 bit, single-cycle pulse at sweep end.
REQ-012 Port pass: output, 1 bit, sweep result, held until the next accepted start.
REQ-013 Port err_count: output, 3 bits, mismatches in the current/last sweep (0..4).
REQ-014 Port vec_idx: output, 2 bits, index of the vector currently driven.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-016 In IDLE, start=1 at a clock edge SHALL be accepted: clear err_count and pass, set vec_idx=0, go to APPLY.
REQ-017 Vectors SHALL be applied in order 00, 01, 10, 11, with dut_in1=vec_idx[1] and dut_in2=vec_idx[0] from APPLY through SAMPLE.
REQ-018 APPLY SHALL last exactly one cycle, then go to SETTLE, or directly to SAMPLE when SETTLE_CYCLES=0.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by an internal down-counter.
REQ-020 SAMPLE SHALL last one cycle; if dut_out != TRUTH_TABLE[vec_idx], err_count SHALL increment by 1 (it never wraps; max 4).
REQ-021 From SAMPLE: if vec_idx==3, go to DONE; otherwise increment vec_idx and go to APPLY.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 pass SHALL be set to 1 in DONE iff err_count==0, including the final vector's mismatch.
REQ-024 busy SHALL be 1 in APPLY, SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-025 start SHALL be ignored in every state except IDLE; start held high through DONE is accepted in the following IDLE cycle.
REQ-026 Timing: with start accepted at edge k, done SHALL be high during the cycle after edge k + 4*(SETTLE_CYCLES+2) (17 cycles for the default).
REQ-027 In IDLE and DONE, dut_in1 and dut_in2 SHALL be 0.

Reset
REQ-028 rst=1 SHALL force state IDLE, with dut_in1, dut_in2, busy, done, pass, err_count and vec_idx all 0, and the settle counter at 0.
REQ-029 Reset mid-sweep SHALL abort the sweep, with no done pulse and pass=0.
REQ-030 rst SHALL take priority over a simultaneous start.

Configuration
REQ-031 Macro GATE_SEQ_FAIL_MASK_EN: when defined, add an output port fail_mask (4 bits) whose bit i is set in SAMPLE when vector i mismatches; it is cleared on reset and on start acceptance, and held after DONE.
REQ-032 When GATE_SEQ_FAIL_MASK_EN is undefined, there SHALL be no fail_mask port or logic, and all other behaviour is identical.

Verification
REQ-033 dut_out driven by a behavioural AND of dut_in1/dut_in2, start pulsed -> done at cycle 17, pass=1, err_count=0.
REQ-034 dut_out tied 0 -> err_count=1, pass=0 (fail_mask=4'b1000 if enabled).
REQ-035 dut_out tied 1 -> err_count=3, pass=0 (fail_mask=4'b0111 if enabled).
REQ-036 rst asserted while vec_idx=2 -> next cycle all outputs 0, state IDLE, no done pulse.
REQ-037 start re-pulsed while busy -> ignored, sweep timing unchanged; start held continuously -> back-to-back sweeps, each done at 17 cycles, 1 IDLE cycle between them.
REQ-038 SETTLE_CYCLES=0 with AND model -> done 9 cycles after start acceptance, pass=1.

Source files
------------

// File: rtl/gate_test_sequencer.sv
// Drives all four input vectors into a 2-input gate and counts mismatches against TRUTH_TABLE.
// Optional build macro GATE_SEQ_FAIL_MASK_EN adds a per-vector fail_mask output.
module gate_test_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  TRUTH_TABLE   = 4'b1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dut_out,
   output logic       dut_in1,
   output logic       dut_in2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
`ifdef GATE_SEQ_FAIL_MASK_EN
   output logic [1:0] vec_idx,
   output logic [3:0] fail_mask
`else
   output logic [1:0] vec_idx
`endif
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned ERR_W = 3;
   localparam int unsigned VEC_W = 2;
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES == 0) ? CNT_W'(0) : CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(4);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [VEC_W-1:0] r_vec_idx;
   logic [ERR_W-1:0] r_err_count;
   logic             r_pass;
   logic             r_done;
   logic             r_busy;
   logic             r_dut_in1;
   logic             r_dut_in2;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [VEC_W-1:0] w_vec_nxt;
   logic [ERR_W-1:0] w_err_nxt;
   logic             w_pass_nxt;
   logic             w_busy_nxt;
   logic             w_mismatch;

`ifdef GATE_SEQ_FAIL_MASK_EN
   logic [3:0]       r_fail_mask;
   logic [3:0]       w_mask_nxt;
`endif

   // Next-state and next-output logic; outputs are registered from these values
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_vec_nxt   = r_vec_idx;
      w_err_nxt   = r_err_count;
      w_pass_nxt  = r_pass;
`ifdef GATE_SEQ_FAIL_MASK_EN
      w_mask_nxt  = r_fail_mask;
`endif
      w_mismatch  = (dut_out != TRUTH_TABLE[r_vec_idx]);

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = APPLY;
               w_vec_nxt   = '0;
               w_err_nxt   = '0;
               w_pass_nxt  = 1'b0;
`ifdef GATE_SEQ_FAIL_MASK_EN
               w_mask_nxt  = '0;
`endif
            end
         end
         APPLY: begin
            if (SETTLE_CYCLES == 0) begin
               w_state_nxt = SAMPLE;
            end else begin
               w_state_nxt = SETTLE;
               w_cnt_nxt   = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (r_cnt == '0) w_state_nxt = SAMPLE;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         SAMPLE: begin
            if (w_mismatch) begin
               if (r_err_count < ERR_MAX) w_err_nxt = r_err_count + ERR_W'(1);
`ifdef GATE_SEQ_FAIL_MASK_EN
               w_mask_nxt[r_vec_idx] = 1'b1;
`endif
            end
            // Pass uses the count that includes this final sample
            if (r_vec_idx == VEC_W'(3)) begin
               w_state_nxt = DONE;
               w_pass_nxt  = (w_err_nxt == '0);
            end else begin
               w_state_nxt = APPLY;
               w_vec_nxt   = r_vec_idx + VEC_W'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      w_busy_nxt = (w_state_nxt == APPLY) || (w_state_nxt == SETTLE) ||
                   (w_state_nxt == SAMPLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_vec_idx   <= '0;
         r_err_count <= '0;
         r_pass      <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_dut_in1   <= 1'b0;
         r_dut_in2   <= 1'b0;
`ifdef GATE_SEQ_FAIL_MASK_EN
         r_fail_mask <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_vec_idx   <= w_vec_nxt;
         r_err_count <= w_err_nxt;
         r_pass      <= w_pass_nxt;
         r_done      <= (w_state_nxt == DONE);
         r_busy      <= w_busy_nxt;
         r_dut_in1   <= w_busy_nxt & w_vec_nxt[1];
         r_dut_in2   <= w_busy_nxt & w_vec_nxt[0];
`ifdef GATE_SEQ_FAIL_MASK_EN
         r_fail_mask <= w_mask_nxt;
`endif
      end
   end

   assign dut_in1   = r_dut_in1;
   assign dut_in2   = r_dut_in2;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err_count;
   assign vec_idx   = r_vec_idx;
`ifdef GATE_SEQ_FAIL_MASK_EN
   assign fail_mask = r_fail_mask;
`endif

endmodule
